bcd_countdown_mmss: RTL

//  MM:SS countdown timer built from four chained BCD down-counter digits with

---
 rtl/bcd_countdown_mmss.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_mmss.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_countdown_mmss
//  Description : MM:SS countdown timer made of four chained BCD down-counter
//                digits with borrow propagation. The digits are preset from
//                the set switches and counting is controlled by start/pause.
//                Expiry at 00:00 is reported as a one-cycle done pulse and a
//                level expired flag.
//                Optional feature macro: COUNTDOWN_ALARM_EN adds an alarm
//                output that toggles on ticks for ALARM_TICKS ticks after
//                expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_mmss #(
    parameter int MAX_MIN_TENS = 5
`ifdef COUNTDOWN_ALARM_EN
    ,
    parameter int ALARM_TICKS  = 10
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] set_mt,
    input  logic [3:0] set_mo,
    input  logic [3:0] set_st,
    input  logic [3:0] set_so,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
`ifdef COUNTDOWN_ALARM_EN
    ,
    output logic       alarm
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_mt_max = 4'(MAX_MIN_TENS);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic       r_running, r_done, r_expired;
    logic       w_done_nxt;

    // Clamped preset values
    logic [3:0] w_ld_mt, w_ld_mo, w_ld_st, w_ld_so;

    // One-second decrement of the current count, with borrow chain
    logic       w_so_borrow, w_st_borrow, w_mo_borrow;
    logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_is_zero, w_dec_zero;

    assign w_ld_mt = (set_mt > c_mt_max) ? c_mt_max : set_mt;
    assign w_ld_mo = (set_mo > 4'd9)     ? 4'd9     : set_mo;
    assign w_ld_st = (set_st > 4'd5)     ? 4'd5     : set_st;
    assign w_ld_so = (set_so > 4'd9)     ? 4'd9     : set_so;

    assign w_so_borrow = (r_so == 4'd0);
    assign w_st_borrow = w_so_borrow && (r_st == 4'd0);
    assign w_mo_borrow = w_st_borrow && (r_mo == 4'd0);

    assign w_dec_so = w_so_borrow ? 4'd9 : r_so - 4'd1;
    assign w_dec_st = !w_so_borrow ? r_st : ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1);
    assign w_dec_mo = !w_st_borrow ? r_mo : ((r_mo == 4'd0) ? 4'd9 : r_mo - 4'd1);
    // Minute tens never underflows: RUN is only ever occupied with a nonzero count
    assign w_dec_mt = w_mo_borrow ? r_mt - 4'd1 : r_mt;

    assign w_is_zero  = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
    assign w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'h0000);

    // Next-state, next-count and done-pulse decode; load > pause > start
    always_comb begin
        w_state_nxt = r_state;
        w_mt_nxt    = r_mt;
        w_mo_nxt    = r_mo;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;
        w_done_nxt  = 1'b0;
        if (load && (r_state != S_RUN)) begin
            w_mt_nxt    = w_ld_mt;
            w_mo_nxt    = w_ld_mo;
            w_st_nxt    = w_ld_st;
            w_so_nxt    = w_ld_so;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (!pause && start && !w_is_zero) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (tick) begin
                        w_mt_nxt = w_dec_mt;
                        w_mo_nxt = w_dec_mo;
                        w_st_nxt = w_dec_st;
                        w_so_nxt = w_dec_so;
                        if (w_dec_zero) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE holds 00:00 until a load
                end
            endcase
        end
    end

    // State, digit and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mt      <= w_mt_nxt;
            r_mo      <= w_mo_nxt;
            r_st      <= w_st_nxt;
            r_so      <= w_so_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= w_done_nxt;
            r_expired <= (w_state_nxt == S_DONE);
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = r_running;
    assign done     = r_done;
    assign expired  = r_expired;

`ifdef COUNTDOWN_ALARM_EN
    localparam int             c_aw         = $clog2(ALARM_TICKS + 1);
    localparam logic [c_aw-1:0] c_alarm_last = c_aw'(ALARM_TICKS);

    logic [c_aw-1:0] r_alarm_cnt;
    logic            r_alarm;

    // Alarm: set on DONE entry, toggles per tick, forced low after ALARM_TICKS ticks
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (w_state_nxt != S_DONE) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (r_state != S_DONE) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
        end else if (tick && (r_alarm_cnt < c_alarm_last)) begin
            r_alarm_cnt <= r_alarm_cnt + 1'b1;
            r_alarm     <= ((r_alarm_cnt + 1'b1) == c_alarm_last) ? 1'b0 : ~r_alarm;
        end
    end

    assign alarm = r_alarm;
`endif

endmodule
`default_nettype wire
